// File: rtl/if_axi_rd_bridge.sv
// Fetch-bus responder to AXI4 single-beat read; request cycle 0 -> ar_valid cycle 1 -> bus_ready cycle 3 at zero AXI latency.
// Requester may drop valid to abort at any point; AR is never retracted and an outstanding beat is drained silently.
module if_axi_rd_bridge #(
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_valid_i,
    input  logic            bus_req_i,
    input  logic [63:0]     bus_addr_i,
    input  logic [1:0]      bus_size_i,
    output logic            bus_ready_o,
    output logic [63:0]     bus_data_read_o,
    output logic [1:0]      bus_resp_o,
    output logic            ar_valid_o,
    input  logic            ar_ready_i,
    output logic [63:0]     ar_addr_o,
    output logic [2:0]      ar_size_o,
    output logic [7:0]      ar_len_o,
    output logic [1:0]      ar_burst_o,
    output logic [ID_W-1:0] ar_id_o,
    input  logic            r_valid_i,
    output logic            r_ready_o,
    input  logic [63:0]     r_data_i,
    input  logic [1:0]      r_resp_i,
    input  logic            r_last_i,
    input  logic [ID_W-1:0] r_id_i
);

    localparam logic       REQ_WRITE   = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [63:0] data_q, data_d;
    logic [1:0]  resp_q, resp_d;
    logic [5:0]  shift;
    logic [1:0]  beat_resp;

    assign shift = {addr_q[2:0], 3'b000};

    // A beat that is not the expected single last beat of our ID is reported as a slave error.
    always_comb begin
        beat_resp = r_resp_i;
        if ((r_id_i != AXI_ID) || !r_last_i) begin
            beat_resp = RESP_SLVERR;
        end else if (r_resp_i == RESP_EXOKAY) begin
            beat_resp = RESP_OKAY;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: begin
                if (bus_valid_i) begin
                    if (bus_req_i == REQ_WRITE) begin
                        resp_d  = RESP_SLVERR;
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        addr_d  = bus_addr_i;
                        size_d  = bus_size_i;
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (ar_ready_i) begin
                    state_d = bus_valid_i ? DATA : DRAIN;
                end
            end
            DATA: begin
                if (r_valid_i) begin
                    data_d  = r_data_i >> shift;
                    resp_d  = beat_resp;
                    state_d = RESP;
                end else if (!bus_valid_i) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (r_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
        end
    end

    // An aborted request in RESP leaves silently, so the pulse is qualified by the live valid.
    assign bus_ready_o     = (state_q == RESP) && bus_valid_i;
    assign bus_data_read_o = bus_ready_o ? data_q : '0;
    assign bus_resp_o      = bus_ready_o ? resp_q : '0;

    assign ar_valid_o = (state_q == ADDR);
    assign ar_addr_o  = addr_q;
    assign ar_size_o  = {1'b0, size_q};
    assign ar_len_o   = 8'd0;
    assign ar_burst_o = 2'b01;
    assign ar_id_o    = AXI_ID;
    assign r_ready_o  = (state_q == DATA) || (state_q == DRAIN);

endmodule

// File: tb/tb_if_axi_rd_bridge.sv
module tb_if_axi_rd_bridge;

    localparam int unsigned     ID_W   = 4;
    localparam logic [ID_W-1:0] AXI_ID = 4'd0;

    typedef struct packed {
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            bus_valid_i = 1'b0;
    logic            bus_req_i = 1'b0;
    logic [63:0]     bus_addr_i = '0;
    logic [1:0]      bus_size_i = '0;
    logic            bus_ready_o;
    logic [63:0]     bus_data_read_o;
    logic [1:0]      bus_resp_o;
    logic            ar_valid_o;
    logic            ar_ready_i = 1'b0;
    logic [63:0]     ar_addr_o;
    logic [2:0]      ar_size_o;
    logic [7:0]      ar_len_o;
    logic [1:0]      ar_burst_o;
    logic [ID_W-1:0] ar_id_o;
    logic            r_valid_i = 1'b0;
    logic            r_ready_o;
    logic [63:0]     r_data_i = '0;
    logic [1:0]      r_resp_i = '0;
    logic            r_last_i = 1'b0;
    logic [ID_W-1:0] r_id_i = '0;

    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   n_exp = 0;
    exp_t sb_q[$];

    if_axi_rd_bridge #(.ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
        .clk(clk), .rst(rst),
        .bus_valid_i(bus_valid_i), .bus_req_i(bus_req_i), .bus_addr_i(bus_addr_i), .bus_size_i(bus_size_i),
        .bus_ready_o(bus_ready_o), .bus_data_read_o(bus_data_read_o), .bus_resp_o(bus_resp_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_size_o(ar_size_o),
        .ar_len_o(ar_len_o), .ar_burst_o(ar_burst_o), .ar_id_o(ar_id_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i), .r_id_i(r_id_i)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endfunction

    // Reference: fetch stage sees the bytes from addr[2:0] upward, zero-filled; errors per beat attributes.
    function automatic exp_t model_rd(input logic [63:0] addr, input logic [63:0] rdata,
                                      input logic [ID_W-1:0] rid, input logic rlast, input logic [1:0] rresp);
        exp_t e;
        int   off;
        off = int'(addr[2:0]);
        for (int i = 0; i < 8; i++) begin
            e.data[i*8 +: 8] = (i + off < 8) ? rdata[(i+off)*8 +: 8] : 8'h00;
        end
        if (rid != AXI_ID || !rlast)  e.resp = 2'b10;
        else if (rresp == 2'b01)      e.resp = 2'b00;
        else                          e.resp = rresp;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && bus_ready_o) begin
            exp_t e;
            pulses++;
            chk("ready_while_valid", bus_valid_i, 1'b1);
            if (sb_q.size() == 0) begin
                chk("unexpected_ready_pulse", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("bus_data", bus_data_read_o, e.data);
                chk("bus_resp", bus_resp_o, e.resp);
            end
        end
    end

    // Drives one request plus the AXI slave side; starts and returns at posedge+1.
    task automatic run_txn(input logic [63:0] addr, input logic [1:0] size, input logic req,
                           input int ar_dly, input int r_dly, input logic [63:0] rdata,
                           input logic [ID_W-1:0] rid, input logic rlast, input logic [1:0] rresp,
                           input int abort_cyc, input int abort_after_ar, output int ready_cyc);
        int c, ar_cnt, r_cnt, ar_cyc;
        bit ar_acc, r_acc, got, aborted, done;
        c = 0; ar_cnt = 0; r_cnt = 0; ar_cyc = -1; ready_cyc = -1;
        ar_acc = 0; r_acc = 0; got = 0; aborted = 0; done = 0;
        bus_valid_i = 1'b1; bus_req_i = req; bus_addr_i = addr; bus_size_i = size;
        r_data_i = rdata; r_id_i = rid; r_last_i = rlast; r_resp_i = rresp;
        if (abort_cyc < 0 && abort_after_ar < 0) begin
            if (req) sb_q.push_back('{resp: 2'b10, data: 64'd0});
            else     sb_q.push_back(model_rd(addr, rdata, rid, rlast, rresp));
            n_exp++;
        end
        while (!done) begin
            if (abort_cyc == c || (ar_acc && abort_after_ar >= 0 && c == ar_cyc + abort_after_ar)) begin
                bus_valid_i = 1'b0;
                aborted = 1;
            end
            ar_ready_i = ar_valid_o && (ar_cnt >= ar_dly);
            r_valid_i  = ar_acc && !r_acc && (r_cnt >= r_dly);
            @(negedge clk);
            chk("ar_valid", ar_valid_o, (!req && c >= 1 && !ar_acc));
            chk("r_ready", r_ready_o, (ar_acc && !r_acc));
            if (ar_valid_o) begin
                chk("ar_addr", ar_addr_o, addr);
                chk("ar_size", ar_size_o, {1'b0, size});
            end
            if (ar_acc && !r_acc) begin
                if (r_valid_i && r_ready_o) r_acc = 1;
                else r_cnt++;
            end
            if (!ar_acc && ar_valid_o) begin
                if (ar_ready_i) begin
                    ar_acc = 1;
                    ar_cyc = c;
                    chk("ar_len", ar_len_o, 8'd0);
                    chk("ar_burst", ar_burst_o, 2'b01);
                    chk("ar_id", ar_id_o, AXI_ID);
                end else begin
                    ar_cnt++;
                end
            end
            if (bus_ready_o) begin
                got = 1;
                ready_cyc = c;
            end
            @(posedge clk);
            #1;
            c++;
            if (got) done = 1;
            else if (aborted && r_acc) done = 1;
            else if (c >= 300) begin
                chk("txn_timeout", 1'b1, 1'b0);
                done = 1;
            end
        end
        bus_valid_i = 1'b0;
        ar_ready_i  = 1'b0;
        r_valid_i   = 1'b0;
        if (aborted) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int rc, p0;
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, p0;
        #2;
        chk("rst_bus_ready", bus_ready_o, 1'b0);
        chk("rst_bus_data", bus_data_read_o, 64'd0);
        chk("rst_bus_resp", bus_resp_o, 2'b00);
        chk("rst_ar_valid", ar_valid_o, 1'b0);
        chk("rst_ar_addr", ar_addr_o, 64'd0);
        chk("rst_ar_size", ar_size_o, 3'd0);
        chk("rst_ar_len", ar_len_o, 8'd0);
        chk("rst_ar_burst", ar_burst_o, 2'b01);
        chk("rst_ar_id", ar_id_o, AXI_ID);
        chk("rst_r_ready", r_ready_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // basic fetch, zero AXI latency
        run_txn(64'h8000_0004, 2'b10, 1'b0, 0, 0, 64'h1234_5678_9ABC_DEF0, AXI_ID, 1'b1, 2'b00, -1, -1, rc);
        chk("basic_latency", rc, 3);
        chk("basic_model", model_rd(64'h8000_0004, 64'h1234_5678_9ABC_DEF0, AXI_ID, 1'b1, 2'b00),
            64'h0000_0000_1234_5678);
        // backpressure on both channels: exactly one pulse
        p0 = pulses;
        run_txn(64'h8000_0013, 2'b00, 1'b0, 5, 7, 64'hA1B2_C3D4_E5F6_0718, AXI_ID, 1'b1, 2'b01, -1, -1, rc);
        chk("bp_one_pulse", pulses - p0, 1);
        // abort in DATA, then a fresh read
        p0 = pulses;
        run_txn(64'h8000_0008, 2'b11, 1'b0, 0, 3, 64'hDEAD_BEEF_0000_1111, AXI_ID, 1'b1, 2'b00, -1, 2, rc);
        chk("abort_data_no_pulse", pulses - p0, 0);
        run_txn(64'h8000_0000, 2'b10, 1'b0, 0, 0, 64'h0BAD_F00D_CAFE_4321, AXI_ID, 1'b1, 2'b00, -1, -1, rc);
        // abort in ADDR while AR is stalled
        p0 = pulses;
        run_txn(64'h8000_0020, 2'b10, 1'b0, 5, 1, 64'h5555_AAAA_5555_AAAA, AXI_ID, 1'b1, 2'b00, 2, -1, rc);
        chk("abort_addr_no_pulse", pulses - p0, 0);
        // errors: write, DECERR passthrough, wrong ID, missing last
        run_txn(64'h8000_0040, 2'b10, 1'b1, 0, 0, 64'h0, AXI_ID, 1'b1, 2'b00, -1, -1, rc);
        chk("write_latency", rc, 1);
        run_txn(64'h8000_0044, 2'b10, 1'b0, 0, 0, 64'h1111_2222_3333_4444, AXI_ID, 1'b1, 2'b11, -1, -1, rc);
        run_txn(64'h8000_0048, 2'b10, 1'b0, 1, 2, 64'h9999_8888_7777_6666, 4'h3, 1'b1, 2'b00, -1, -1, rc);
        run_txn(64'h8000_004F, 2'b00, 1'b0, 0, 1, 64'hFEDC_BA98_7654_3210, AXI_ID, 1'b0, 2'b00, -1, -1, rc);

        // asynchronous reset in DATA
        bus_valid_i = 1'b1; bus_req_i = 1'b0; bus_addr_i = 64'h100; bus_size_i = 2'b11; ar_ready_i = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_r_ready", r_ready_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ar_valid", ar_valid_o, 1'b0);
        chk("arst_r_ready", r_ready_o, 1'b0);
        chk("arst_bus_ready", bus_ready_o, 1'b0);
        chk("arst_bus_data", bus_data_read_o, 64'd0);
        chk("arst_ar_addr", ar_addr_o, 64'd0);
        chk("arst_ar_size", ar_size_o, 3'd0);
        bus_valid_i = 1'b0;
        ar_ready_i  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_txn(64'h0, 2'b11, 1'b0, 0, 0, 64'h0102_0304_0506_0708, AXI_ID, 1'b1, 2'b00, -1, -1, rc);
        chk("post_rst_latency", rc, 3);

        // randomized back-to-back traffic with occasional aborts and errors
        for (int n = 0; n < 60; n++) begin
            logic [63:0]     a, d;
            logic [ID_W-1:0] id;
            logic            rq, lst;
            int              ad, rd, ab_c, ab_a, m, k;
            a   = {$urandom, $urandom};
            d   = {$urandom, $urandom};
            rq  = ($urandom_range(0, 7) == 0);
            id  = ($urandom_range(0, 7) == 0) ? ID_W'($urandom_range(0, 15)) : AXI_ID;
            lst = ($urandom_range(0, 7) != 0);
            ad  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            ab_c = -1;
            ab_a = -1;
            m = $urandom_range(0, 7);
            if (!rq && m == 0) begin
                ab_c = $urandom_range(1, 2);
                ad   = $urandom_range(1, 4);
            end else if (!rq && m == 1) begin
                k    = $urandom_range(1, 3);
                ab_a = k;
                rd   = k + $urandom_range(0, 2);
            end
            run_txn(a, 2'($urandom_range(0, 3)), rq, ad, rd, d, id, lst, 2'($urandom_range(0, 3)), ab_c, ab_a, rc);
        end

        @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        chk("pulse_count", pulses, n_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_axi_rd_bridge.md
Name: if_axi_rd_bridge

Overview:
- Responder end of the instruction-fetch bus.
- Accepts single-beat read requests from the fetch stage: valid/addr/size/req in; ready/data_read/resp out.
- Converts each request into one AXI4 single-beat read (AR/R channels) toward the memory system.
- Returns the beat lane-aligned so the requested bytes sit at bit 0, which is where the fetch stage takes the instruction.

Parameters:
- AXI_ID, 4'd0: constant driven on ar_id_o; also the expected r_id_i.
- ID_W, 4: AXI ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- bus_valid_i  in  1  request valid. Held by the requester until the ready handshake, or dropped on abort.
- bus_req_i  in  1  request type; REQ_READ=1'b0, REQ_WRITE=1'b1.
- bus_addr_i  in  64  byte address.
- bus_size_i  in  2  00 byte, 01 half, 10 word, 11 dword.
- bus_ready_o  out  1  one-cycle pulse; data and resp are valid in the same cycle.
- bus_data_read_o  out  64  beat shifted right by addr[2:0]*8, zero-filled at the top.
- bus_resp_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR (AXI rresp passthrough).
- ar_valid_o  out  1  AXI read-address valid.
- ar_ready_i  in  1  AXI read-address ready.
- ar_addr_o  out  64  AXI read address.
- ar_size_o  out  3  AXI arsize = {1'b0, size}.
- ar_len_o  out  8  constant 0.
- ar_burst_o  out  2  constant 2'b01 (INCR).
- ar_id_o  out  ID_W  constant AXI_ID.
- r_valid_i  in  1  AXI read-data valid.
- r_ready_o  out  1  AXI read-data ready.
- r_data_i  in  64  AXI read data.
- r_resp_i  in  2  AXI read response.
- r_last_i  in  1  AXI last beat.
- r_id_i  in  ID_W  AXI read ID.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - All outputs are 0 except the constants ar_len_o, ar_burst_o and ar_id_o.
  - Captured address, size and data registers are cleared.
  - An in-flight AXI read is abandoned; the slave is reset with the system.
- States: IDLE, ADDR, DATA, RESP, DRAIN.
- IDLE:
  - bus_valid_i=1 with REQ_READ: capture addr and size, go to ADDR.
  - bus_valid_i=1 with REQ_WRITE: load resp=2'b10 and data=0, go to RESP. No AXI traffic is issued.
- ADDR:
  - ar_valid_o=1, ar_addr_o = captured address.
  - On ar_ready_i: go to DATA, or to DRAIN if bus_valid_i=0 that cycle.
  - ar_valid_o stays high and ar_addr_o stable until accepted, even if bus_valid_i drops (no AXI valid retraction).
- DATA:
  - r_ready_o=1.
  - On r_valid_i: register the shifted data and r_resp_i, go to RESP.
  - If bus_valid_i=0 at any DATA cycle before r_valid_i: go to DRAIN.
- DRAIN:
  - r_ready_o=1.
  - On r_valid_i: discard the beat and go to IDLE. No bus_ready_o is issued.
- RESP:
  - If bus_valid_i=1: bus_ready_o=1 for exactly this cycle with the registered data and resp, then go to IDLE.
  - If bus_valid_i=0 (abort): go to IDLE silently.
- Request capture: once a request leaves IDLE, later changes to addr/size/req are ignored.
- Back-to-back: the cycle after RESP is IDLE, so a new request is accepted there. Maximum throughput is one fetch per 4 cycles at zero AXI latency.
- Latency: valid in cycle 0 → ar_valid_o in cycle 1. With ar_ready_i in cycle 1 and r_valid_i in cycle 2, bus_ready_o asserts in cycle 3.
- Error handling:
  - r_id_i ≠ AXI_ID or r_last_i=0 on the beat: treat as SLVERR (resp 2'b10) and keep the data.
  - r_resp_i=2'b01 (EXOKAY) is reported as 2'b00.
- Shift rule: shift = {addr[2:0], 3'b000}; output = r_data_i >> shift.
- bus_ready_o is never asserted while bus_valid_i=0.

Test Plan:
- Basic fetch: read at addr 0x8000_0004, size 10, ar_ready=1 immediately, r_valid one cycle later with r_data=0x1234_5678_9ABC_DEF0 → ar_addr_o=0x8000_0004, ar_size_o=3'b010; bus_ready_o pulses at cycle 3 with data=0x0000_0000_1234_5678, resp=00.
- Backpressure: ar_ready held low 5 cycles, r_valid delayed 7 cycles → ar_valid_o and ar_addr_o stable throughout; exactly one bus_ready_o pulse; r_ready_o high only in DATA.
- Abort in DATA: bus_valid_i drops 2 cycles after AR accept, then r_valid arrives → no bus_ready_o; FSM returns to IDLE; a following read at 0x8000_0000 completes with the correct (new) data.
- Abort in ADDR: bus_valid_i drops while ar_ready=0 → ar_valid_o remains high until accepted; then DRAIN consumes one beat; no bus_ready_o.
- Errors: (a) REQ_WRITE request → bus_ready_o at cycle 1 with resp=10, no ar_valid_o. (b) read with r_resp=11 → resp=11. (c) read with r_id=4'h3 → resp=10.
- Async reset: assert rst=0 in DATA state (between clock edges) → all outputs zero immediately; after release, a new read at 0x0 completes normally.
